fb_scan_reader: RTL and testbench
=================================

Name: fb_scan_reader

Overview:
- Downstream consumer of the dual-port frame RAM.
- Drives RAM read port B (en_b/re_b/adr_b) and absorbs its 1-cycle registered read latency.
- Emits the frame as a valid/ready pixel stream with frame/line markers for the display/output stage.
- Single-frame or continuous raster scan.

Parameters:
- adr_width, 13, RAM address width (matches RAM instance).
- dat_width, 16, pixel word width.
- frame_words, 4096, words per frame; addresses 0..frame_words-1.
- line_words, 64, words per line; frame_words must be a multiple of it.

Ports:
- clk  in  1  sole clock; also drives RAM clk_b.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a scan at address 0.
- stop  in  1  pulse: abort the scan.
- continuous  in  1  level, sampled at each frame end: 1 = rescan without a gap.
- busy  out  1  high while not IDLE.
- frame_done  out  1  one-cycle pulse after the eof word handshakes.
- en_b  out  1  RAM port-B enable.
- re_b  out  1  RAM port-B read strobe; always equal to en_b.
- adr_b  out  adr_width  RAM read address.
- dat_b  in  dat_width  RAM read data, valid the cycle after en_b&re_b.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  dat_width  pixel word.
- m_sof  out  1  first word of frame (address 0).
- m_eol  out  1  last word of a line.
- m_eof  out  1  last word of frame.

Behaviour:
- Reset values: busy=0, frame_done=0, en_b=re_b=0, adr_b=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0; state IDLE; counters and buffer cleared.
- Reset mid-scan: all state clears next edge; any in-flight RAM word is dropped.
- States:
  - IDLE: start -> RUN, address and column counters = 0.
  - RUN: issue reads; after the read of address frame_words-1 is issued -> DRAIN.
  - DRAIN: no issues.
    - If continuous=1 at entry, go straight back to RUN at address 0; the issue stream has no gap.
    - Otherwise wait until the buffer is empty and nothing is in flight -> IDLE.
- en_b, re_b and adr_b are registered outputs. The first read is issued in the cycle immediately after start is sampled.
- Issue rule: issue when (occupancy + inflight) < 2, or when a pop (m_valid & m_ready) occurs in the same cycle. This gives 1 word/cycle sustained while m_ready=1.
- The returned dat_b is written into a 2-entry FIFO. Tags sof/eol/eof are computed at issue time and pipelined alongside the read.
- Latency: m_valid first rises 2 cycles after the first en_b cycle.
- Stream rules:
  - m_data and tags are held stable while m_valid & !m_ready.
  - m_valid never drops without a handshake, except on stop or rst.
- Counters: adr_b wraps frame_words-1 -> 0. The column counter wraps line_words-1 -> 0; m_eol is set on the wrap.
- start while busy is ignored.
- stop (any state): next cycle state = IDLE, en_b=0, FIFO flushed, m_valid=0, in-flight word discarded, no frame_done. If start and stop arrive in the same cycle, stop wins.
- frame_done pulses in the cycle after the eof handshake. In continuous mode it pulses every frame.
- busy falls on entry to IDLE.

Decomposition:
- Shared package fb_pkg: FB_ADR_W, FB_DAT_W, FB_FRAME_WORDS, FB_LINE_WORDS; scan state encoding (IDLE, RUN, DRAIN); pixel-tag struct {sof, eol, eof}.
- Sub-module fb_skid_buf: 2-entry synchronous FIFO of {tag, data}, with push, pop, flush, occupancy outputs.

Test Plan:
- Single frame, m_ready=1, frame_words=16, line_words=4, continuous=0: adr_b issued 0..15 on consecutive cycles; m_data equals RAM[0..15] with no gaps; m_eol on words 3,7,11,15; m_sof on word 0; m_eof on word 15; frame_done once; busy returns to 0.
- Backpressure: m_ready toggles 1,0,0,1 repeating: no word lost or duplicated; m_data stable while stalled; en_b never issues past the 2-slot budget.
- Continuous with frame_words=16, m_ready=1: after word 15, word 0 with m_sof follows in the very next cycle; frame_done pulses every 16 handshakes.
- stop asserted mid-line while m_valid=1 and m_ready=0: next cycle m_valid=0, en_b=0, busy=0; a following start restarts at adr_b=0 with m_sof on the first word.
- rst asserted during RUN with a read in flight: all outputs return to reset values next cycle; the dropped word never appears on m_data.
- start asserted while busy: ignored; the in-progress addresses are unaffected.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scan reader.
//   FB_* localparams : default address/data widths and frame geometry.
//   scan_state_e     : raster scan state encoding.
//   pix_tag_t        : per-pixel frame/line markers carried next to each word.
package fb_pkg;

    localparam int FB_ADR_W       = 13;
    localparam int FB_DAT_W       = 16;
    localparam int FB_FRAME_WORDS = 4096;
    localparam int FB_LINE_WORDS  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

endpackage

// File: rtl/fb_scan_reader_if.sv
// Pixel stream interface between the scan reader and the display stage.
//   m_valid/m_ready : valid/ready handshake
//   m_data          : pixel word
//   m_sof/m_eol/m_eof : first word of frame, last word of line, last word of frame
// master = scan reader, slave = downstream consumer.
interface fb_scan_reader_if
    import fb_pkg::*;
#(
    parameter int DAT_W = FB_DAT_W
);
    logic             m_valid;
    logic             m_ready;
    logic [DAT_W-1:0] m_data;
    logic             m_sof;
    logic             m_eol;
    logic             m_eof;

    modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
    modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/fb_skid_buf.sv
// Two-entry synchronous FIFO of {tag, data} that lands RAM read data.
//   i_push/i_tag/i_data : write side (ignored when full unless popping)
//   i_pop               : read side (ignored when empty)
//   i_flush             : drop all entries
//   o_valid/o_tag/o_data: head entry, o_occ: number of stored entries
module fb_skid_buf
    import fb_pkg::*;
#(
    parameter int DAT_W = FB_DAT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  pix_tag_t         i_tag,
    input  logic [DAT_W-1:0] i_data,
    output logic             o_valid,
    output pix_tag_t         o_tag,
    output logic [DAT_W-1:0] o_data,
    output logic [1:0]       o_occ
);
    localparam int ENT_W = DAT_W + 3;

    logic [ENT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop & (r_occ != 2'd0);
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= {ENT_W{1'b0}};
            r_mem[1] <= {ENT_W{1'b0}};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_tag, i_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_valid         = (r_occ != 2'd0);
    assign {o_tag, o_data} = r_mem[r_rd_ptr];
    assign o_occ           = r_occ;
endmodule

// File: rtl/fb_scan_reader.sv
// Raster scan reader: walks frame RAM port B and emits a tagged pixel stream.
//   clk, rst            : clock (also RAM clk_b), synchronous active-high reset
//   i_start/i_stop      : begin scan at address 0 / abort scan
//   i_continuous        : sampled at frame end, 1 = rescan without a gap
//   o_busy/o_frame_done : not idle / pulse after the eof handshake
//   o_en_b/o_re_b/o_adr_b, i_dat_b : RAM read port B (1-cycle read latency)
//   m_if                : pixel stream (master side)
module fb_scan_reader
    import fb_pkg::*;
#(
    parameter int ADR_W       = FB_ADR_W,
    parameter int DAT_W       = FB_DAT_W,
    parameter int FRAME_WORDS = FB_FRAME_WORDS,
    parameter int LINE_WORDS  = FB_LINE_WORDS
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_continuous,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_en_b,
    output logic             o_re_b,
    output logic [ADR_W-1:0] o_adr_b,
    input  logic [DAT_W-1:0] i_dat_b,
    fb_scan_reader_if.master m_if
);
    localparam int               COL_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(FRAME_WORDS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

    scan_state_e      r_state, w_state_nxt;
    logic             r_cont;
    logic             r_en_b;
    logic [ADR_W-1:0] r_adr_b;
    logic [ADR_W-1:0] r_nxt_adr;
    logic [COL_W-1:0] r_col;
    pix_tag_t         r_tag_s0;
    pix_tag_t         r_tag_s1;
    logic             r_rd_vld;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_issue;
    logic             w_budget;
    logic             w_pop;
    logic             w_push;
    logic [ADR_W-1:0] w_iss_adr;
    logic [COL_W-1:0] w_iss_col;
    pix_tag_t         w_tag;
    logic             w_valid;
    pix_tag_t         w_out_tag;
    logic [DAT_W-1:0] w_out_data;
    logic [1:0]       w_occ;

    assign w_pop = w_valid & m_if.m_ready;

    // The RAM output register only reloads on en_b, so a word that cannot be
    // pushed yet stays valid on i_dat_b. The budget below guarantees en_b is
    // never high while such a word is waiting.
    assign w_push = r_rd_vld & ((w_occ != 2'd2) | w_pop);

    // Slots counted are buffered words plus the word landing this cycle.
    assign w_budget = (({1'b0, w_occ} + {2'b00, r_rd_vld}) < 3'd2) | w_pop;

    assign w_iss_adr = (r_state == ST_IDLE) ? {ADR_W{1'b0}} : r_nxt_adr;
    assign w_iss_col = (r_state == ST_IDLE) ? {COL_W{1'b0}} : r_col;
    assign w_tag     = {(w_iss_adr == {ADR_W{1'b0}}), (w_iss_col == LAST_COL), (w_iss_adr == LAST_ADR)};

    // Scan FSM next state and read-issue decision for the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_budget) begin
                    w_issue = 1'b1;
                    if (w_iss_adr == LAST_ADR) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_cont) begin
                    // Rescan decision was taken at frame end; keep issuing.
                    w_state_nxt = ST_RUN;
                    w_issue     = w_budget;
                end else if ((w_occ == 2'd0) && !r_rd_vld && !r_en_b) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_issue     = 1'b0;
        end else begin
            w_issue = w_issue;
        end
    end

    // State, read port, address/column counters and tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cont       <= 1'b0;
            r_en_b       <= 1'b0;
            r_adr_b      <= {ADR_W{1'b0}};
            r_nxt_adr    <= {ADR_W{1'b0}};
            r_col        <= {COL_W{1'b0}};
            r_tag_s0     <= 3'b000;
            r_tag_s1     <= 3'b000;
            r_rd_vld     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_pop & w_out_tag.eof & ~i_stop;
            r_en_b       <= w_issue;
            if ((r_state == ST_RUN) && (w_state_nxt == ST_DRAIN)) begin
                r_cont <= i_continuous;
            end
            if (w_issue) begin
                r_adr_b   <= w_iss_adr;
                r_tag_s0  <= w_tag;
                r_nxt_adr <= (w_iss_adr == LAST_ADR) ? {ADR_W{1'b0}} : w_iss_adr + {{(ADR_W-1){1'b0}}, 1'b1};
                r_col     <= (w_iss_col == LAST_COL) ? {COL_W{1'b0}} : w_iss_col + {{(COL_W-1){1'b0}}, 1'b1};
            end
            if (r_en_b) begin
                r_tag_s1 <= r_tag_s0;
            end
            if (i_stop) begin
                r_nxt_adr <= {ADR_W{1'b0}};
                r_col     <= {COL_W{1'b0}};
                r_rd_vld  <= 1'b0;
            end else begin
                r_rd_vld <= r_en_b | (r_rd_vld & ~w_push);
            end
        end
    end

    fb_skid_buf #(.DAT_W(DAT_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_stop),
        .i_tag   (r_tag_s1),
        .i_data  (i_dat_b),
        .o_valid (w_valid),
        .o_tag   (w_out_tag),
        .o_data  (w_out_data),
        .o_occ   (w_occ)
    );

    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_en_b       = r_en_b;
    assign o_re_b       = r_en_b;
    assign o_adr_b      = r_adr_b;

    assign m_if.m_valid = w_valid;
    assign m_if.m_data  = w_out_data;
    assign m_if.m_sof   = w_out_tag.sof;
    assign m_if.m_eol   = w_out_tag.eol;
    assign m_if.m_eof   = w_out_tag.eof;
endmodule

// File: tb/tb_fb_scan_reader.sv
module tb_fb_scan_reader;
    localparam int ADR_W = 13;
    localparam int DAT_W = 16;
    localparam int FW    = 16;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst, start, stop, cont;
    logic             busy, frame_done, en_b, re_b;
    logic [ADR_W-1:0] adr_b;
    logic [DAT_W-1:0] dat_b;
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    fb_scan_reader_if #(.DAT_W(DAT_W)) s_if ();

    fb_scan_reader #(.ADR_W(ADR_W), .DAT_W(DAT_W), .FRAME_WORDS(FW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .i_continuous(cont),
        .o_busy(busy), .o_frame_done(frame_done), .o_en_b(en_b), .o_re_b(re_b),
        .o_adr_b(adr_b), .i_dat_b(dat_b), .m_if(s_if)
    );

    function automatic logic [DAT_W-1:0] ram_val(input int a);
        return 16'h1000 + 16'(a * 37);
    endfunction

    // Frame RAM port B: registered read, output held while not enabled.
    always @(posedge clk) begin
        if (en_b && re_b) dat_b <= ram_val(int'(adr_b) % FW);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_fdone"}, frame_done, 0);
        chk({pfx, "_en_b"}, en_b, 0);
        chk({pfx, "_re_b"}, re_b, 0);
        chk({pfx, "_adr_b"}, adr_b, 0);
        chk({pfx, "_valid"}, s_if.m_valid, 0);
        chk({pfx, "_data"}, s_if.m_data, 0);
        chk({pfx, "_tags"}, {s_if.m_sof, s_if.m_eol, s_if.m_eof}, 0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 60 && busy; k++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int issued, popped, fd_cnt;
        logic stalled_prev;
        logic [DAT_W-1:0] prev_data;

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; s_if.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single frame, m_ready=1: reads 0..15 back to back, stream 2 cycles behind.
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("t1_en_b", en_b, (c <= 16));
            if (c <= 16) chk("t1_adr", adr_b, c - 1);
            chk("t1_valid", s_if.m_valid, (c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) begin
                chk("t1_data", s_if.m_data, ram_val(c - 3));
                chk("t1_sof", s_if.m_sof, (c == 3));
                chk("t1_eol", s_if.m_eol, ((c - 3) % LW == LW - 1));
                chk("t1_eof", s_if.m_eof, (c == 18));
            end
            chk("t1_fdone", frame_done, (c == 19));
            if (c <= 18) chk("t1_busy_hi", busy, 1);
            if (c >= 21) chk("t1_busy_lo", busy, 0);
        end

        // Backpressure with m_ready pattern 1,0,0,1.
        issued = 0; popped = 0; fd_cnt = 0; stalled_prev = 1'b0; prev_data = '0;
        start = 1'b1;
        for (int c = 0; c < 150 && popped < FW; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (en_b) issued++;
            chk("t2_budget", ((issued - popped) <= 3), 1);
            if (frame_done) fd_cnt++;
            if (stalled_prev) begin
                chk("t2_hold_valid", s_if.m_valid, 1);
                chk("t2_hold_data", s_if.m_data, prev_data);
            end
            s_if.m_ready = (c % 4 == 0) || (c % 4 == 3);
            if (s_if.m_valid && s_if.m_ready) begin
                chk("t2_data", s_if.m_data, ram_val(popped));
                chk("t2_sof", s_if.m_sof, (popped == 0));
                chk("t2_eol", s_if.m_eol, (popped % LW == LW - 1));
                chk("t2_eof", s_if.m_eof, (popped == FW - 1));
                popped++;
            end
            stalled_prev = s_if.m_valid && !s_if.m_ready;
            prev_data    = s_if.m_data;
        end
        chk("t2_words", popped, FW);
        s_if.m_ready = 1'b1;
        for (int k = 0; k < 60 && busy; k++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (en_b) issued++;
        end
        chk("t2_idle", busy, 0);
        chk("t2_fdone_cnt", fd_cnt, 1);
        chk("t2_issued", issued, FW);

        // Continuous mode: sof word follows eof word with no gap.
        cont = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c >= 3) begin
                chk("t3_valid", s_if.m_valid, 1);
                chk("t3_data", s_if.m_data, ram_val((c - 3) % FW));
                chk("t3_sof", s_if.m_sof, ((c - 3) % FW == 0));
                chk("t3_eof", s_if.m_eof, ((c - 3) % FW == FW - 1));
            end
            chk("t3_fdone", frame_done, (c == 19 || c == 35));
        end

        // Stop mid-line while stalled.
        s_if.m_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall_valid", s_if.m_valid, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; cont = 1'b0; s_if.m_ready = 1'b1;
        chk("t4_valid", s_if.m_valid, 0);
        chk("t4_en_b", en_b, 0);
        chk("t4_busy", busy, 0);
        chk("t4_fdone", frame_done, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_quiet_valid", s_if.m_valid, 0);
            chk("t4_quiet_en_b", en_b, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_re_en_b", en_b, 1);
        chk("t4_re_adr", adr_b, 0);
        repeat (2) @(negedge clk);
        chk("t4_re_valid", s_if.m_valid, 1);
        chk("t4_re_data", s_if.m_data, ram_val(0));
        chk("t4_re_sof", s_if.m_sof, 1);
        wait_idle("t4_idle");

        // Reset during RUN with a read in flight.
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_inflight", en_b, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("t5");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_no_word", s_if.m_valid, 0);
            chk("t5_idle", busy, 0);
        end

        // start while busy is ignored.
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = (c == 3);
            chk("t6_en_b", en_b, 1);
            chk("t6_adr", adr_b, c - 1);
        end
        wait_idle("t6_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
